// File: rtl/fan_ctrl_multi.sv
// N-channel fan controller: one shared incremental PI update per enabled cycle, per-channel
// PWM from a shared period counter. Define FAN_KICKSTART_EN to compile the kick-start logic.
module fan_ctrl_multi #(
    parameter int CHANNELS      = 2,
    parameter int ADC_BITWIDTH  = 4,
    parameter int FRAC_BITWIDTH = 6,
    parameter int PWM_PERIOD    = 19,
    parameter int PWM_MIN       = 3,
    parameter int KICK_PERIODS  = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic                                  clk_en_i,
    input  logic [CHANNELS*ADC_BITWIDTH-1:0]      adc_i,
    input  logic [CHANNELS*ADC_BITWIDTH-1:0]      set_i,
    input  logic                                  sample_valid_i,
    output logic                                  sample_ready_o,
    input  logic [ADC_BITWIDTH+FRAC_BITWIDTH-1:0] b2_i,
    input  logic [ADC_BITWIDTH+FRAC_BITWIDTH-1:0] b0_i,
    output logic [CHANNELS-1:0]                   pwm_o,
    output logic [CHANNELS*ADC_BITWIDTH-1:0]      duty_o,
    output logic [CHANNELS-1:0]                   sat_o
);
    localparam int CW      = ADC_BITWIDTH + FRAC_BITWIDTH;
    localparam int AW      = CW + 2;
    localparam int EW      = ADC_BITWIDTH + 1;
    localparam int SW      = AW + ADC_BITWIDTH + 1;
    localparam int IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TW      = $clog2(PWM_PERIOD + 1);
    localparam int U_MAX_I = ((1 << ADC_BITWIDTH) - 1) << FRAC_BITWIDTH;
    localparam logic signed [SW-1:0] U_MAX = SW'(U_MAX_I);

    if (CHANNELS < 1 || PWM_PERIOD < (1 << ADC_BITWIDTH) - 1 || KICK_PERIODS < 1) begin : g_param_check
        $error("fan_ctrl_multi: invalid parameter set");
    end

    typedef enum logic {IDLE, CALC} state_t;

    state_t                            state, state_nx;
    logic [IW-1:0]                     idx, idx_nx;
    logic                              accept, upd;
    logic [CHANNELS*ADC_BITWIDTH-1:0]  adc_q, set_q;
    logic signed [AW-1:0]              acc    [CHANNELS];
    logic signed [EW-1:0]              e_prev [CHANNELS];

    logic [ADC_BITWIDTH-1:0]           adc_sel, set_sel;
    logic signed [EW-1:0]              e_cur;
    logic signed [SW-1:0]              acc_x, ep_x, e_x, b2_x, b0_x, sum_full;
    logic signed [AW-1:0]              u_next;
    logic                              sat_next;

    logic [TW-1:0]                     cnt;
    logic                              wrap;
    logic [TW-1:0]                     thr_pend [CHANNELS];
    logic [TW-1:0]                     thr_act  [CHANNELS];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx       = state;
        idx_nx         = idx;
        sample_ready_o = 1'b0;
        accept         = 1'b0;
        upd            = 1'b0;
        case (state)
            IDLE: begin
                sample_ready_o = 1'b1;
                if (sample_valid_i) begin
                    accept   = 1'b1;
                    state_nx = CALC;
                    idx_nx   = '0;
                end
            end
            CALC: begin
                if (clk_en_i) begin
                    upd = 1'b1;
                    if (idx == IW'(CHANNELS - 1)) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sum is formed at SW bits, wide enough that extreme coefficients cannot wrap before the clamp.
    always_comb begin
        adc_sel  = adc_q[idx*ADC_BITWIDTH +: ADC_BITWIDTH];
        set_sel  = set_q[idx*ADC_BITWIDTH +: ADC_BITWIDTH];
        e_cur    = $signed({1'b0, set_sel}) - $signed({1'b0, adc_sel});
        acc_x    = SW'(acc[idx]);
        ep_x     = SW'(e_prev[idx]);
        e_x      = SW'(e_cur);
        b2_x     = SW'($signed(b2_i));
        b0_x     = SW'($signed(b0_i));
        sum_full = acc_x + b2_x * e_x + b0_x * ep_x;
        sat_next = 1'b1;
        if (sum_full[SW-1]) begin
            u_next = '0;
        end else if (sum_full > U_MAX) begin
            u_next = U_MAX[AW-1:0];
        end else begin
            u_next   = sum_full[AW-1:0];
            sat_next = 1'b0;
        end
    end

    // NOTE: the per-channel accumulator and error arrays are reset explicitly; they are state, not RAM.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            adc_q <= '0;
            set_q <= '0;
            sat_o <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i]    <= '0;
                e_prev[i] <= '0;
            end
        end else begin
            if (accept) begin
                adc_q <= adc_i;
                set_q <= set_i;
            end
            if (upd) begin
                acc[idx]    <= u_next;
                e_prev[idx] <= e_cur;
                sat_o[idx]  <= sat_next;
            end
        end
    end

    always_comb begin
        duty_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_o[i*ADC_BITWIDTH +: ADC_BITWIDTH] = acc[i][FRAC_BITWIDTH +: ADC_BITWIDTH];
            thr_pend[i] = TW'(acc[i][FRAC_BITWIDTH +: ADC_BITWIDTH]);
            if (thr_pend[i] != '0 && thr_pend[i] < TW'(PWM_MIN))
                thr_pend[i] = TW'(PWM_MIN);
        end
    end

    assign wrap = clk_en_i && (cnt == TW'(PWM_PERIOD - 1));

`ifdef FAN_KICKSTART_EN
    localparam int KW = $clog2(KICK_PERIODS + 1);
    logic [KW-1:0] kick [CHANNELS];
`endif

    // Active thresholds change only at the wrap, so each PWM period is whole.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                thr_act[i] <= '0;
`ifdef FAN_KICKSTART_EN
                kick[i]    <= '0;
`endif
            end
        end else if (clk_en_i) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    thr_act[i] <= thr_pend[i];
`ifdef FAN_KICKSTART_EN
                    if (thr_act[i] == '0 && thr_pend[i] != '0)
                        kick[i] <= KW'(KICK_PERIODS);
                    else if (thr_pend[i] == '0)
                        kick[i] <= '0;
                    else if (kick[i] != '0)
                        kick[i] <= kick[i] - 1'b1;
`endif
                end
            end
        end
    end

    always_comb begin
        pwm_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef FAN_KICKSTART_EN
            pwm_o[i] = (cnt < thr_act[i]) || (kick[i] != '0);
`else
            pwm_o[i] = (cnt < thr_act[i]);
`endif
        end
    end

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Self-checking bench for fan_ctrl_multi: a queue-based behavioural model compared every
// negedge, directed scenarios with literal expectations, then randomized stimulus.
module tb_fan_ctrl_multi;
    localparam int CH     = 2;
    localparam int ADC    = 4;
    localparam int FRAC   = 6;
    localparam int PERIOD = 19;
    localparam int PMIN   = 3;
    localparam int KICK   = 4;
    localparam int CW     = ADC + FRAC;
    localparam int PW     = CH * ADC;
    localparam int UMAX   = ((1 << ADC) - 1) << FRAC;
`ifdef FAN_KICKSTART_EN
    localparam int SETTLE = (KICK + 2) * PERIOD;
`else
    localparam int SETTLE = 2 * PERIOD;
`endif

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          clk_en = 1'b0;
    logic          valid  = 1'b0;
    logic [PW-1:0] adc    = '0;
    logic [PW-1:0] set_v  = '0;
    logic [CW-1:0] b2     = '0;
    logic [CW-1:0] b0     = '0;
    logic          ready;
    logic [CH-1:0] pwm;
    logic [CH-1:0] sat;
    logic [PW-1:0] duty;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: plain integers plus a queue of channels awaiting update.
    int m_u[CH], m_ep[CH], m_sat[CH], m_act[CH], m_kick[CH], m_adc[CH], m_set[CH];
    int m_cnt;
    int m_q[$];

    always #5 clk = ~clk;

    fan_ctrl_multi #(
        .CHANNELS(CH), .ADC_BITWIDTH(ADC), .FRAC_BITWIDTH(FRAC),
        .PWM_PERIOD(PERIOD), .PWM_MIN(PMIN), .KICK_PERIODS(KICK)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en),
        .adc_i(adc), .set_i(set_v),
        .sample_valid_i(valid), .sample_ready_o(ready),
        .b2_i(b2), .b0_i(b0),
        .pwm_o(pwm), .duty_o(duty), .sat_o(sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int thr_of(input int u);
        int d;
        d = u >> FRAC;
        if (d == 0) return 0;
        return (d < PMIN) ? PMIN : d;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_u[c] = 0; m_ep[c] = 0; m_sat[c] = 0; m_act[c] = 0;
            m_kick[c] = 0; m_adc[c] = 0; m_set[c] = 0;
        end
        m_cnt = 0;
        m_q.delete();
    endfunction

    // One rising edge worth of behaviour, using the inputs present at that edge.
    function automatic void model_edge();
        int nt, c, e, s;
        if (clk_en) begin
            if (m_cnt == PERIOD - 1) begin
                for (int k = 0; k < CH; k++) begin
                    nt = thr_of(m_u[k]);
`ifdef FAN_KICKSTART_EN
                    if (m_act[k] == 0 && nt != 0) m_kick[k] = KICK;
                    else if (nt == 0)             m_kick[k] = 0;
                    else if (m_kick[k] > 0)       m_kick[k]--;
`endif
                    m_act[k] = nt;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (m_q.size() != 0) begin
            if (clk_en) begin
                c = m_q.pop_front();
                e = m_set[c] - m_adc[c];
                s = m_u[c] + int'($signed(b2)) * e + int'($signed(b0)) * m_ep[c];
                if (s < 0)         begin m_u[c] = 0;    m_sat[c] = 1; end
                else if (s > UMAX) begin m_u[c] = UMAX; m_sat[c] = 1; end
                else               begin m_u[c] = s;    m_sat[c] = 0; end
                m_ep[c] = e;
            end
        end else if (valid) begin
            for (int k = 0; k < CH; k++) begin
                m_adc[k] = int'(adc[k*ADC +: ADC]);
                m_set[k] = int'(set_v[k*ADC +: ADC]);
                m_q.push_back(k);
            end
        end
    endfunction

    function automatic logic [PW-1:0] exp_duty();
        logic [PW-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c*ADC +: ADC] = ADC'(m_u[c] >> FRAC);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_pwm();
        logic [CH-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c] = (m_kick[c] > 0) || (m_cnt < m_act[c]);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_sat();
        logic [CH-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c] = (m_sat[c] != 0);
        return r;
    endfunction

    always @(negedge clk) begin
        check("cyc_ready", 32'(ready), 32'(m_q.size() == 0));
        check("cyc_duty",  32'(duty),  32'(exp_duty()));
        check("cyc_sat",   32'(sat),   32'(exp_sat()));
        check("cyc_pwm",   32'(pwm),   32'(exp_pwm()));
    end

    task automatic step();
        @(posedge clk);
        if (rstn) model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        model_reset();
        repeat (2) step();
        rstn = 1'b1;
    endtask

    task automatic send(input int a0, input int s0, input int a1, input int s1);
        adc   = {ADC'(a1), ADC'(a0)};
        set_v = {ADC'(s1), ADC'(s0)};
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic round(input int a0, input int s0, input int a1, input int s1);
        send(a0, s0, a1, s1);
        repeat (CH) step();
    endtask

    task automatic count_high(input int n, output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        for (int i = 0; i < n; i++) begin
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0, h1;
        model_reset();
        clk_en = 1'b1;
        b2 = CW'(64);
        b0 = '0;
        repeat (2) step();
        rstn = 1'b1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_duty",  32'(duty),  32'd0);
        check("reset_pwm",   32'(pwm),   32'd0);
        check("reset_sat",   32'(sat),   32'd0);

        // Reset mid-round: ch0 already updated, ch1 pending.
        send(4, 10, 2, 2);
        step();
        check("t1_ch0_first", 32'(duty), 32'h06);
        rstn = 1'b0;
        model_reset();
        step();
        check("t1_in_reset_duty", 32'(duty), 32'd0);
        rstn = 1'b1;
        check("t1_release_ready", 32'(ready), 32'd1);
        check("t1_release_duty",  32'(duty),  32'd0);
        check("t1_release_pwm",   32'(pwm),   32'd0);
        step();

        // Latency and ready return.
        adc   = {ADC'(2), ADC'(4)};
        set_v = {ADC'(2), ADC'(10)};
        valid = 1'b1;
        check("t2_ready_accept", 32'(ready), 32'd1);
        step();
        valid = 1'b0;
        check("t2_ready_busy1", 32'(ready), 32'd0);
        step();
        check("t2_duty_ch0", 32'(duty), 32'h06);
        check("t2_ready_busy2", 32'(ready), 32'd0);
        step();
        check("t2_ready_back", 32'(ready), 32'd1);
        check("t2_duty", 32'(duty), 32'h06);
        check("t2_model_u", 32'(m_u[0]), 32'd384);

        repeat (SETTLE) step();
        count_high(PERIOD, h0, h1);
        check("t3_high_ch0", 32'(h0), 32'd6);
        check("t3_high_ch1", 32'(h1), 32'd0);

        // Clamp at full scale.
        apply_reset();
        round(0, 15, 0, 0);
        check("t4_duty1", 32'(duty), 32'h0F);
        check("t4_sat1",  32'(sat),  32'd0);
        round(0, 15, 0, 0);
        check("t4_duty2", 32'(duty), 32'h0F);
        check("t4_sat2",  32'(sat),  32'd1);
        check("t4_model_u", 32'(m_u[0]), 32'd960);
        repeat (SETTLE) step();
        count_high(PERIOD, h0, h1);
        check("t4_high_ch0", 32'(h0), 32'd15);

        // Minimum on-time, then back to zero.
        apply_reset();
        b2 = CW'(16);
        round(0, 4, 0, 0);
        check("t5_duty1", 32'(duty), 32'h01);
        repeat (SETTLE) step();
        count_high(PERIOD, h0, h1);
        check("t5_high_min", 32'(h0), 32'd3);
        round(4, 0, 0, 0);
        check("t5_duty0", 32'(duty), 32'h00);
        check("t5_sat0",  32'(sat),  32'd0);
        repeat (SETTLE) step();
        count_high(PERIOD, h0, h1);
        check("t5_high_zero", 32'(h0), 32'd0);

        // Two-term update with e_prev, and a valid pulse while busy.
        apply_reset();
        b2 = CW'(9);
        b0 = CW'(-8);
        round(0, 6, 0, 0);
        check("t6_model_u1", 32'(m_u[0]), 32'd54);
        check("t6_duty1", 32'(duty), 32'h00);
        send(0, 6, 0, 0);
        adc   = {ADC'(0), ADC'(0)};
        set_v = {ADC'(15), ADC'(15)};
        valid = 1'b1;
        check("t6_busy_ready", 32'(ready), 32'd0);
        step();
        valid = 1'b0;
        step();
        step();
        check("t6_model_u2", 32'(m_u[0]), 32'd60);
        check("t6_duty2", 32'(duty), 32'h00);
        check("t6_idle", 32'(ready), 32'd1);
        round(0, 6, 0, 0);
        check("t6_duty3", 32'(duty), 32'h01);

`ifdef FAN_KICKSTART_EN
        apply_reset();
        b2 = CW'(64);
        b0 = '0;
        round(4, 10, 0, 0);
        for (int t = 0; t < 3 * PERIOD && m_act[0] == 0; t++) step();
        check("kick_wait", 32'(m_act[0] != 0), 32'd1);
        count_high(KICK * PERIOD, h0, h1);
        check("kick_full", 32'(h0), 32'(KICK * PERIOD));
        count_high(PERIOD, h0, h1);
        check("kick_after", 32'(h0), 32'd6);
`endif

        // Randomized traffic with gapped enables, coefficient changes and rare resets.
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            clk_en = ($urandom_range(0, 9) < 7);
            valid  = ($urandom_range(0, 3) == 0);
            adc    = PW'($urandom);
            set_v  = PW'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin b2 = CW'(-(1 << (CW - 1))); b0 = CW'((1 << (CW - 1)) - 1); end
                    1: begin b2 = CW'((1 << (CW - 1)) - 1); b0 = CW'(-(1 << (CW - 1))); end
                    2: begin b2 = CW'($urandom); b0 = CW'($urandom); end
                    default: begin
                        b2 = CW'($urandom_range(0, 80));
                        b0 = CW'(0 - int'($urandom_range(0, 60)));
                    end
                endcase
            end
            if ($urandom_range(0, 999) == 0) apply_reset();
            step();
        end
        clk_en = 1'b1;
        valid  = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
